// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: ALUOp encodings, opcode constants and control-word layout.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    ALU_RTYPE = 2'b00,
    ALU_ADD   = 2'b01,
    ALU_SUB   = 2'b10
  } aluOp_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Bit ordering of the control word, MSB first; shared with the decoder.
  typedef struct packed {
    logic RegDst;
    logic ALUSrc;
    logic MemtoReg;
    logic RegWrite;
    logic MemWrite;
    logic Branch;
    logic Jump;
    logic ExtOp;
    logic MemRead;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus: decoded instruction from ID and the registered copy held in EX.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemWrite;
  logic              id_Branch, id_Jump, id_ExtOp, id_MemRead;
  logic [1:0]        id_ALUOp;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_pc4;
  logic [15:0]       id_imm16;

  logic              ex_valid;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemWrite;
  logic              ex_Branch, ex_Jump, ex_ExtOp, ex_MemRead;
  logic [1:0]        ex_ALUOp;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_pc4, ex_imm;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemWrite,
           id_Branch, id_Jump, id_ExtOp, id_MemRead, id_ALUOp,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_pc4, id_imm16,
    input  ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemWrite,
           ex_Branch, ex_Jump, ex_ExtOp, ex_MemRead, ex_ALUOp,
           ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_pc4, ex_imm
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemWrite,
           id_Branch, id_Jump, id_ExtOp, id_MemRead, id_ALUOp,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_pc4, id_imm16,
    output ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemWrite,
           ex_Branch, ex_Jump, ex_ExtOp, ex_MemRead, ex_ALUOp,
           ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_pc4, ex_imm
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load held in EX.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic              idValid,
  input  logic              idJump,
  input  logic              idRegDst,
  input  logic              idBranch,
  input  logic              idMemWrite,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              flush,
  output logic              stall
);
  logic usesRs;
  logic usesRt;
  logic rsHit;
  logic rtHit;

  always_comb begin
    usesRs = idValid & ~idJump;
    usesRt = idValid & (idRegDst | idBranch | idMemWrite);
    rsHit  = usesRs & (exRt == idRs);
    rtHit  = usesRt & (exRt == idRt);
    // r0 is never a real load destination, so it cannot create a dependency.
    stall  = exValid & exMemRead & (exRt != '0) & (rsHit | rtHit) & ~flush;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension, load-use bubble insertion and stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  input  logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);
  ctrl_t             idCtrl;
  ctrl_t             exCtrl;
  aluOp_e            exAluOp;
  logic              exValid;
  logic [REG_AW-1:0] exRs, exRt, exRd;
  logic [DATA_W-1:0] exRsData, exRtData, exPc4, exImm;
  logic [DATA_W-1:0] idImm;
  logic [CNT_W-1:0]  stallCnt;

  assign idCtrl = '{
    RegDst:   bus.id_RegDst,
    ALUSrc:   bus.id_ALUSrc,
    MemtoReg: bus.id_MemtoReg,
    RegWrite: bus.id_RegWrite,
    MemWrite: bus.id_MemWrite,
    Branch:   bus.id_Branch,
    Jump:     bus.id_Jump,
    ExtOp:    bus.id_ExtOp,
    MemRead:  bus.id_MemRead
  };

  assign idImm = bus.id_ExtOp ? {{(DATA_W-16){bus.id_imm16[15]}}, bus.id_imm16}
                              : {{(DATA_W-16){1'b0}}, bus.id_imm16};

  hazard_detect #(.REG_AW(REG_AW)) uHazard (
    .exValid    (exValid),
    .exMemRead  (exCtrl.MemRead),
    .exRt       (exRt),
    .idValid    (bus.id_valid),
    .idJump     (bus.id_Jump),
    .idRegDst   (bus.id_RegDst),
    .idBranch   (bus.id_Branch),
    .idMemWrite (bus.id_MemWrite),
    .idRs       (bus.id_rs),
    .idRt       (bus.id_rt),
    .flush      (flush),
    .stall      (stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid  <= 1'b0;
      exCtrl   <= CTRL_BUBBLE;
      exAluOp  <= ALU_RTYPE;
      exRs     <= '0;
      exRt     <= '0;
      exRd     <= '0;
      exRsData <= '0;
      exRtData <= '0;
      exPc4    <= '0;
      exImm    <= '0;
      stallCnt <= '0;
    end else begin
      // Data fields follow ID unconditionally; only valid/control are squashed on a bubble.
      exRs     <= bus.id_rs;
      exRt     <= bus.id_rt;
      exRd     <= bus.id_rd;
      exRsData <= bus.id_rs_data;
      exRtData <= bus.id_rt_data;
      exPc4    <= bus.id_pc4;
      exImm    <= idImm;
      if (flush || stall) begin
        exValid <= 1'b0;
        exCtrl  <= CTRL_BUBBLE;
        exAluOp <= ALU_RTYPE;
      end else begin
        exValid <= bus.id_valid;
        exCtrl  <= bus.id_valid ? idCtrl : CTRL_BUBBLE;
        exAluOp <= (bus.id_Jump || !bus.id_valid) ? ALU_RTYPE : aluOp_e'(bus.id_ALUOp);
      end
      if (stall && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign bus.ex_valid    = exValid;
  assign bus.ex_RegDst   = exCtrl.RegDst;
  assign bus.ex_ALUSrc   = exCtrl.ALUSrc;
  assign bus.ex_MemtoReg = exCtrl.MemtoReg;
  assign bus.ex_RegWrite = exCtrl.RegWrite;
  assign bus.ex_MemWrite = exCtrl.MemWrite;
  assign bus.ex_Branch   = exCtrl.Branch;
  assign bus.ex_Jump     = exCtrl.Jump;
  assign bus.ex_ExtOp    = exCtrl.ExtOp;
  assign bus.ex_MemRead  = exCtrl.MemRead;
  assign bus.ex_ALUOp    = exAluOp;
  assign bus.ex_rs       = exRs;
  assign bus.ex_rt       = exRt;
  assign bus.ex_rd       = exRd;
  assign bus.ex_rs_data  = exRsData;
  assign bus.ex_rt_data  = exRtData;
  assign bus.ex_pc4      = exPc4;
  assign bus.ex_imm      = exImm;
  assign stall_cnt       = stallCnt;
endmodule
